// File: rtl/adc_emulator.sv
`default_nettype none
// ============================================================================
// Module      : adc_emulator
// Description : Responder model of the serial ADC. Watches adc_conv/adc_clk
//               from the capture front end and shifts back a frame of
//               2 zero pad bits, a SAMPLE_W-bit sample (MSB first) and
//               2 zero pad bits. Samples come from an internal pattern
//               generator (constant / ramp / triangle / alternating).
// Ports       : osc_clk      - sole clock, rising edge
//               reset        - synchronous, active-low
//               adc_clk      - serial clock from initiator (asynchronous)
//               adc_conv     - conversion strobe, high = convert/idle,
//                              low = readout
//               pattern_sel  - 0 const, 1 ramp, 2 triangle, 3 alternating
//               sample_in    - constant value for mode 0
//               step_in      - increment for ramp and triangle
//               adc_data     - serial data to initiator
//               sample_cur   - sample latched into current/last frame
//               frame_done   - 1-cycle pulse on frame completion
//               frame_abort  - 1-cycle pulse when adc_conv rises mid-frame
//               frame_count  - completed frames, wrapping
// Options     : ADC_NOISE_EN - when defined, a 16-bit LFSR adds -4..+3
//               of saturating noise to every generated sample.
// Revision    : 1.0 - initial release
// ============================================================================
module adc_emulator #(
    parameter int SAMPLE_W    = 12,
    parameter int FRAME_BITS  = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic                osc_clk,
    input  logic                reset,
    input  logic                adc_clk,
    input  logic                adc_conv,
    input  logic [1:0]          pattern_sel,
    input  logic [SAMPLE_W-1:0] sample_in,
    input  logic [SAMPLE_W-1:0] step_in,
    output logic                adc_data,
    output logic [SAMPLE_W-1:0] sample_cur,
    output logic                frame_done,
    output logic                frame_abort,
    output logic [15:0]         frame_count
);

    localparam int c_CNT_W = $clog2(FRAME_BITS + 1);
    localparam logic [c_CNT_W-1:0]  c_CNT_LAST   = c_CNT_W'(FRAME_BITS);
    localparam logic [SAMPLE_W-1:0] c_SAMPLE_MAX = '1;

    localparam logic [2:0] c_ST_IDLE  = 3'd0;
    localparam logic [2:0] c_ST_LOAD  = 3'd1;
    localparam logic [2:0] c_ST_SHIFT = 3'd2;
    localparam logic [2:0] c_ST_DONE  = 3'd3;
    localparam logic [2:0] c_ST_WAIT  = 3'd4;

    // ------------------------------------------------------------------
    // Input synchronizers and edge detection
    // ------------------------------------------------------------------
    logic [SYNC_STAGES-1:0] r_clk_sync;
    logic [SYNC_STAGES-1:0] r_conv_sync;
    logic                   r_clk_prev;
    logic                   r_conv_prev;

    always_ff @(posedge osc_clk) begin
        if (!reset) begin
            r_clk_sync  <= '0;
            r_conv_sync <= '0;
            r_clk_prev  <= 1'b0;
            r_conv_prev <= 1'b0;
        end else begin
            // Shift form works for any depth, including a single stage.
            r_clk_sync  <= (r_clk_sync << 1)  | SYNC_STAGES'(adc_clk);
            r_conv_sync <= (r_conv_sync << 1) | SYNC_STAGES'(adc_conv);
            r_clk_prev  <= r_clk_sync[SYNC_STAGES-1];
            r_conv_prev <= r_conv_sync[SYNC_STAGES-1];
        end
    end

    logic w_clk_s;
    logic w_conv_s;
    logic w_clk_rise;
    logic w_clk_fall;
    logic w_conv_rise;
    logic w_conv_fall;

    assign w_clk_s     = r_clk_sync[SYNC_STAGES-1];
    assign w_conv_s    = r_conv_sync[SYNC_STAGES-1];
    assign w_clk_rise  =  w_clk_s  & ~r_clk_prev;
    assign w_clk_fall  = ~w_clk_s  &  r_clk_prev;
    assign w_conv_rise =  w_conv_s & ~r_conv_prev;
    assign w_conv_fall = ~w_conv_s &  r_conv_prev;

    // ------------------------------------------------------------------
    // Pattern generator
    // ------------------------------------------------------------------
    logic [SAMPLE_W-1:0] r_acc;
    logic                r_dir;      // 0 = counting up, 1 = counting down
    logic                r_alt;
    logic [SAMPLE_W-1:0] w_base;
    logic [SAMPLE_W-1:0] w_gen;
    logic [SAMPLE_W-1:0] w_acc_nxt;
    logic                w_dir_nxt;
    logic                w_alt_nxt;
    logic [SAMPLE_W:0]   w_up_sum;
    logic                w_advance;

    assign w_up_sum = {1'b0, r_acc} + {1'b0, step_in};

    always_comb begin
        w_base = r_acc;
        case (pattern_sel)
            2'd0:    w_base = sample_in;
            2'd3:    w_base = r_alt ? c_SAMPLE_MAX : '0;
            default: w_base = r_acc;
        endcase
    end

    always_comb begin
        w_acc_nxt = r_acc;
        w_dir_nxt = r_dir;
        w_alt_nxt = r_alt;
        case (pattern_sel)
            2'd1: w_acc_nxt = w_up_sum[SAMPLE_W-1:0];
            2'd2: begin
                if (!r_dir) begin
                    // Saturate at full scale and turn around there.
                    if (w_up_sum >= {1'b0, c_SAMPLE_MAX}) begin
                        w_acc_nxt = c_SAMPLE_MAX;
                        w_dir_nxt = 1'b1;
                    end else begin
                        w_acc_nxt = w_up_sum[SAMPLE_W-1:0];
                    end
                end else begin
                    if (step_in >= r_acc) begin
                        w_acc_nxt = '0;
                        w_dir_nxt = 1'b0;
                    end else begin
                        w_acc_nxt = r_acc - step_in;
                    end
                end
            end
            2'd3:    w_alt_nxt = ~r_alt;
            default: w_acc_nxt = r_acc;
        endcase
    end

`ifdef ADC_NOISE_EN
    localparam logic [15:0] c_LFSR_SEED = 16'hACE1;

    logic [15:0]         r_lfsr;
    logic                w_lfsr_fb;
    logic [SAMPLE_W+1:0] w_noise_sum;
    logic [SAMPLE_W+1:0] w_noise_diff;

    // Fibonacci taps 16,14,13,11.
    assign w_lfsr_fb    = r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10];
    // base + lfsr[2:0] - 4, computed as an unsigned sum so that the
    // negative case shows up as "sum below 4".
    assign w_noise_sum  = {2'b00, w_base} + {{(SAMPLE_W-1){1'b0}}, r_lfsr[2:0]};
    assign w_noise_diff = w_noise_sum - (SAMPLE_W+2)'(4);

    always_comb begin
        if (w_noise_sum < (SAMPLE_W+2)'(4)) begin
            w_gen = '0;
        end else if (w_noise_diff > {2'b00, c_SAMPLE_MAX}) begin
            w_gen = c_SAMPLE_MAX;
        end else begin
            w_gen = w_noise_diff[SAMPLE_W-1:0];
        end
    end

    always_ff @(posedge osc_clk) begin
        if (!reset) begin
            r_lfsr <= c_LFSR_SEED;
        end else if (w_advance) begin
            r_lfsr <= {r_lfsr[14:0], w_lfsr_fb};
        end
    end
`else
    assign w_gen = w_base;
`endif

    always_ff @(posedge osc_clk) begin
        if (!reset) begin
            r_acc <= '0;
            r_dir <= 1'b0;
            r_alt <= 1'b0;
        end else if (w_advance) begin
            r_acc <= w_acc_nxt;
            r_dir <= w_dir_nxt;
            r_alt <= w_alt_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Frame state machine
    // ------------------------------------------------------------------
    logic [2:0]            r_state;
    logic [2:0]            w_state_nxt;
    logic [FRAME_BITS-1:0] r_shift;
    logic [FRAME_BITS-1:0] w_shift_nxt;
    logic [FRAME_BITS-1:0] w_frame;
    logic [c_CNT_W-1:0]    r_bit_cnt;
    logic [c_CNT_W-1:0]    w_bit_cnt_nxt;
    logic                  r_armed;
    logic                  w_armed_nxt;
    logic                  r_adc_data;
    logic                  w_adc_data_nxt;
    logic [SAMPLE_W-1:0]   r_sample_cur;
    logic [SAMPLE_W-1:0]   w_sample_nxt;
    logic                  r_frame_done;
    logic                  w_done_nxt;
    logic                  r_frame_abort;
    logic                  w_abort_nxt;
    logic [15:0]           r_frame_count;
    logic [15:0]           w_count_nxt;

    assign w_frame = {2'b00, w_gen, 2'b00};

    always_comb begin
        w_state_nxt    = r_state;
        w_shift_nxt    = r_shift;
        w_bit_cnt_nxt  = r_bit_cnt;
        w_armed_nxt    = r_armed;
        w_adc_data_nxt = r_adc_data;
        w_sample_nxt   = r_sample_cur;
        w_done_nxt     = 1'b0;
        w_abort_nxt    = 1'b0;
        w_count_nxt    = r_frame_count;
        w_advance      = 1'b0;
        case (r_state)
            c_ST_IDLE: begin
                w_adc_data_nxt = 1'b0;
                // Only an edge starts a frame; a level held low does not.
                if (w_conv_fall) begin
                    w_state_nxt = c_ST_LOAD;
                end
            end
            c_ST_LOAD: begin
                if (w_conv_rise) begin
                    w_state_nxt    = c_ST_IDLE;
                    w_abort_nxt    = 1'b1;
                    w_adc_data_nxt = 1'b0;
                end else begin
                    w_shift_nxt    = w_frame;
                    w_sample_nxt   = w_gen;
                    w_adc_data_nxt = w_frame[FRAME_BITS-1];
                    w_bit_cnt_nxt  = '0;
                    w_armed_nxt    = 1'b0;
                    w_state_nxt    = c_ST_SHIFT;
                end
            end
            c_ST_SHIFT: begin
                if (w_conv_rise) begin
                    w_state_nxt    = c_ST_IDLE;
                    w_abort_nxt    = 1'b1;
                    w_adc_data_nxt = 1'b0;
                end else if (r_bit_cnt == c_CNT_LAST) begin
                    w_state_nxt = c_ST_DONE;
                end else if (w_clk_rise) begin
                    w_armed_nxt   = 1'b1;
                    w_bit_cnt_nxt = r_bit_cnt + c_CNT_W'(1);
                end else if (w_clk_fall && r_armed) begin
                    // A fall is only honoured after the initiator has
                    // sampled the bit currently on the line.
                    w_shift_nxt    = r_shift << 1;
                    w_adc_data_nxt = r_shift[FRAME_BITS-2];
                    w_armed_nxt    = 1'b0;
                end
            end
            c_ST_DONE: begin
                w_done_nxt     = 1'b1;
                w_count_nxt    = r_frame_count + 16'd1;
                w_advance      = 1'b1;
                w_adc_data_nxt = 1'b0;
                w_state_nxt    = c_ST_WAIT;
            end
            c_ST_WAIT: begin
                w_adc_data_nxt = 1'b0;
                if (w_conv_s) begin
                    w_state_nxt = c_ST_IDLE;
                end
            end
            default: begin
                w_adc_data_nxt = 1'b0;
                w_state_nxt    = c_ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge osc_clk) begin
        if (!reset) begin
            r_state       <= c_ST_IDLE;
            r_shift       <= '0;
            r_bit_cnt     <= '0;
            r_armed       <= 1'b0;
            r_adc_data    <= 1'b0;
            r_sample_cur  <= '0;
            r_frame_done  <= 1'b0;
            r_frame_abort <= 1'b0;
            r_frame_count <= '0;
        end else begin
            r_state       <= w_state_nxt;
            r_shift       <= w_shift_nxt;
            r_bit_cnt     <= w_bit_cnt_nxt;
            r_armed       <= w_armed_nxt;
            r_adc_data    <= w_adc_data_nxt;
            r_sample_cur  <= w_sample_nxt;
            r_frame_done  <= w_done_nxt;
            r_frame_abort <= w_abort_nxt;
            r_frame_count <= w_count_nxt;
        end
    end

    assign adc_data    = r_adc_data;
    assign sample_cur  = r_sample_cur;
    assign frame_done  = r_frame_done;
    assign frame_abort = r_frame_abort;
    assign frame_count = r_frame_count;

endmodule
`default_nettype wire

// File: tb/tb_adc_emulator.sv
`default_nettype none
// ============================================================================
// Module      : tb_adc_emulator
// Description : Directed self-checking bench for adc_emulator. Plays the
//               initiator side of the conversion/readout protocol and
//               compares serial bits, latched samples, pulses and counters
//               against hand-computed values.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_adc_emulator;

    logic        osc_clk;
    logic        reset;
    logic        adc_clk;
    logic        adc_conv;
    logic [1:0]  pattern_sel;
    logic [11:0] sample_in;
    logic [11:0] step_in;
    logic        adc_data;
    logic [11:0] sample_cur;
    logic        frame_done;
    logic        frame_abort;
    logic [15:0] frame_count;

    int checks = 0;
    int errors = 0;
    int done_cnt = 0;
    int abort_cnt = 0;

    adc_emulator dut (
        .osc_clk     (osc_clk),
        .reset       (reset),
        .adc_clk     (adc_clk),
        .adc_conv    (adc_conv),
        .pattern_sel (pattern_sel),
        .sample_in   (sample_in),
        .step_in     (step_in),
        .adc_data    (adc_data),
        .sample_cur  (sample_cur),
        .frame_done  (frame_done),
        .frame_abort (frame_abort),
        .frame_count (frame_count)
    );

    initial osc_clk = 1'b0;
    always #5 osc_clk = ~osc_clk;

    // Count high cycles of each pulse; a stretched pulse shows up as an
    // extra count.
    always @(posedge osc_clk) begin
        if (frame_done)  done_cnt  <= done_cnt + 1;
        if (frame_abort) abort_cnt <= abort_cnt + 1;
    end

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge osc_clk);
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Full conversion; the initiator samples adc_data just before each rise.
    task automatic run_frame(input int h, output logic [15:0] bits);
        bits = '0;
        adc_conv = 1'b0;
        wait_cyc(h);
        for (int i = 0; i < 16; i++) begin
            bits = {bits[14:0], adc_data};
            adc_clk = 1'b1;
            wait_cyc(h);
            adc_clk = 1'b0;
            wait_cyc(h);
        end
        adc_conv = 1'b1;
        wait_cyc(h);
    endtask

    task automatic partial_frame(input int h, input int nrise);
        adc_conv = 1'b0;
        wait_cyc(h);
        for (int i = 0; i < nrise; i++) begin
            adc_clk = 1'b1;
            wait_cyc(h);
            adc_clk = 1'b0;
            wait_cyc(h);
        end
        adc_conv = 1'b1;
        wait_cyc(h);
    endtask

    logic [15:0] bits;
    logic [11:0] exp_ramp [5];
    logic [11:0] exp_tri  [5];
    int          d0;
    int          a0;

    initial begin
        exp_ramp = '{12'h000, 12'h400, 12'h800, 12'hC00, 12'h000};
        exp_tri  = '{12'h000, 12'h800, 12'hFFF, 12'h7FF, 12'h000};

        reset       = 1'b0;
        adc_clk     = 1'b0;
        adc_conv    = 1'b1;
        pattern_sel = 2'd0;
        sample_in   = 12'hABC;
        step_in     = 12'h000;
        wait_cyc(3);

        // Reset state
        check("rst_adc_data",    32'(adc_data),    32'h0);
        check("rst_sample_cur",  32'(sample_cur),  32'h0);
        check("rst_frame_done",  32'(frame_done),  32'h0);
        check("rst_frame_abort", 32'(frame_abort), 32'h0);
        check("rst_frame_count", 32'(frame_count), 32'h0);
        reset = 1'b1;
        wait_cyc(6);

        // Mode 0, slow serial clock (osc/128)
        d0 = done_cnt;
        run_frame(64, bits);
        check("m0_bits",        32'(bits),        32'h2AF0);
        check("m0_reader_byte", 32'(bits[13:6]),  32'hAB);
        check("m0_sample_cur",  32'(sample_cur),  32'hABC);
        check("m0_done_pulses", 32'(done_cnt - d0), 32'h1);
        check("m0_frame_count", 32'(frame_count), 32'h1);

        // Mode 1 ramp with wrap
        pattern_sel = 2'd1;
        step_in     = 12'h400;
        for (int i = 0; i < 5; i++) begin
            run_frame(8, bits);
            check($sformatf("ramp_sample_%0d", i), 32'(sample_cur), 32'(exp_ramp[i]));
            if (i == 1) check("ramp_bits_1", 32'(bits), 32'h1000);
        end
        check("ramp_frame_count", 32'(frame_count), 32'h6);

        // Reset pulse in the middle of a frame
        pattern_sel = 2'd0;
        sample_in   = 12'h5A5;
        adc_conv    = 1'b0;
        wait_cyc(8);
        for (int i = 0; i < 4; i++) begin
            adc_clk = 1'b1; wait_cyc(8);
            adc_clk = 1'b0; wait_cyc(8);
        end
        check("pre_rst_sample_cur", 32'(sample_cur), 32'h5A5);
        adc_clk = 1'b1;
        wait_cyc(2);
        reset = 1'b0;
        wait_cyc(1);
        reset = 1'b1;
        check("midrst_adc_data",    32'(adc_data),    32'h0);
        check("midrst_sample_cur",  32'(sample_cur),  32'h0);
        check("midrst_frame_done",  32'(frame_done),  32'h0);
        check("midrst_frame_abort", 32'(frame_abort), 32'h0);
        check("midrst_frame_count", 32'(frame_count), 32'h0);
        // adc_conv still low but never fell since reset: no frame
        d0 = done_cnt;
        adc_clk = 1'b0;
        wait_cyc(8);
        for (int i = 0; i < 16; i++) begin
            adc_clk = 1'b1; wait_cyc(8);
            adc_clk = 1'b0; wait_cyc(8);
        end
        check("lowconv_no_frame", 32'(done_cnt - d0), 32'h0);
        check("lowconv_count",    32'(frame_count),   32'h0);
        check("lowconv_data",     32'(adc_data),      32'h0);
        adc_conv = 1'b1;
        wait_cyc(8);

        // Mode 2 triangle from a freshly cleared accumulator
        pattern_sel = 2'd2;
        step_in     = 12'h800;
        for (int i = 0; i < 5; i++) begin
            run_frame(8, bits);
            check($sformatf("tri_sample_%0d", i), 32'(sample_cur), 32'(exp_tri[i]));
        end
        check("tri_frame_count", 32'(frame_count), 32'h5);

        // Abort after 7 rises; accumulator is 0x800 here
        pattern_sel = 2'd1;
        step_in     = 12'h010;
        d0 = done_cnt;
        a0 = abort_cnt;
        partial_frame(8, 7);
        check("abort_pulses",      32'(abort_cnt - a0), 32'h1);
        check("abort_no_done",     32'(done_cnt - d0),  32'h0);
        check("abort_adc_data",    32'(adc_data),       32'h0);
        check("abort_frame_count", 32'(frame_count),    32'h5);
        check("abort_sample_cur",  32'(sample_cur),     32'h800);
        run_frame(8, bits);
        check("post_abort_sample", 32'(sample_cur),  32'h800);
        check("post_abort_bits",   32'(bits),        32'h2000);
        check("post_abort_count",  32'(frame_count), 32'h6);
        run_frame(8, bits);
        check("post_abort_next",   32'(sample_cur),  32'h810);

        // Mode 3 alternating
        pattern_sel = 2'd3;
        run_frame(8, bits);
        check("alt_sample_0", 32'(sample_cur), 32'h000);
        run_frame(8, bits);
        check("alt_sample_1", 32'(sample_cur), 32'hFFF);
        check("alt_bits_1",   32'(bits),       32'h3FFC);

        // Constant zero over many frames: noise may only lift it to 0..3
        pattern_sel = 2'd0;
        sample_in   = 12'h000;
        for (int i = 0; i < 64; i++) begin
            run_frame(6, bits);
`ifdef ADC_NOISE_EN
            check($sformatf("noise_range_%0d", i), 32'(sample_cur <= 12'h003), 32'h1);
`else
            check($sformatf("zero_sample_%0d", i), 32'(sample_cur), 32'h0);
`endif
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/adc_emulator.md
Name: adc_emulator

Overview:
Synthesizable responder model of the serial ADC: the other end of the ADC conversion/readout protocol that the capture front end initiates. It watches adc_conv and adc_clk from the initiator and shifts back a 16-bit frame on adc_data: 2 zero pad bits, a 12-bit sample MSB first, then 2 zero pad bits. Samples come from an internal pattern generator. It lets the capture, FIFO and Pi-link path run on hardware and in simulation without the physical ADC.

Parameters:
SAMPLE_W, 12, sample width; frame is always 2 + SAMPLE_W + 2 bits.
FRAME_BITS, 16, bits per frame (must equal SAMPLE_W + 4).
SYNC_STAGES, 2, synchronizer depth for adc_clk and adc_conv.

Ports:
osc_clk  in  1  sole clock; all state updates on its rising edge.
reset  in  1  synchronous, active-low reset.
adc_clk  in  1  serial clock from the initiator; asynchronous to osc_clk.
adc_conv  in  1  conversion strobe from the initiator; high = convert/idle, low = readout.
pattern_sel  in  2  0 = constant, 1 = ramp, 2 = triangle, 3 = alternating.
sample_in  in  12  constant value for mode 0.
step_in  in  12  increment for modes 1 and 2.
adc_data  out  1  serial data to the initiator.
sample_cur  out  12  sample latched into the current or last frame.
frame_done  out  1  one-cycle pulse when a full frame completes.
frame_abort  out  1  one-cycle pulse when adc_conv rises mid-frame.
frame_count  out  16  completed frames, wraps at 0xFFFF to 0.

Behaviour:
- Reset (reset==0 at an osc_clk edge): state IDLE, adc_data=0, sample_cur=0, frame_done=0, frame_abort=0, frame_count=0, pattern accumulator=0, triangle direction=up, synchronizers cleared.
- adc_clk and adc_conv each pass through SYNC_STAGES flops. Edge detect compares the last synchronized value with the previous one, giving 1-cycle rise/fall strobes.
- States:
  - IDLE: adc_data=0. A synchronized adc_conv fall moves to LOAD.
  - LOAD (1 cycle): shift_reg <= {2'b00, gen_sample, 2'b00}; sample_cur <= gen_sample; adc_data <= shift_reg MSB (bit 15 = 0); bit_cnt=0; armed=0; go to SHIFT.
  - SHIFT:
    - adc_clk rise: armed=1, bit_cnt++.
    - adc_clk fall with armed=1: shift left, present next bit, armed=0.
    - adc_clk fall with armed=0 is ignored. This covers the first fall after adc_conv drops, before bit 15 has been sampled.
    - When bit_cnt reaches FRAME_BITS: go to DONE.
  - DONE (1 cycle): frame_done=1, frame_count++, pattern generator advances, adc_data=0, go to WAIT.
  - WAIT: adc_data=0 until synchronized adc_conv is high, then go to IDLE.
- Abort: a synchronized adc_conv rise in LOAD or SHIFT goes to IDLE with frame_abort=1. The frame is not counted and the generator does not advance.
- adc_conv low in IDLE with no fall edge (for example, low straight out of reset) does not start a frame. Only a fall edge starts one.
- Generator (gen_sample, advances only in DONE):
  - Mode 0: sample_in.
  - Mode 1: acc += step_in, modulo 4096.
  - Mode 2: up, acc = min(acc + step, 4095); on reaching 4095 set dir=down. Down, acc = max(acc - step, 0); on reaching 0 set dir=up.
  - Mode 3: toggles 0x000 / 0xFFF, starting at 0x000.
  - Changing pattern_sel takes effect at the next LOAD. acc is retained across mode changes.

Optional Feature:
ADC_NOISE_EN defined:
- 16-bit Fibonacci LFSR (taps 16,14,13,11), seeded 0xACE1 on reset, stepped once per DONE.
- gen_sample = sat(base + (lfsr[2:0] - 4)), clamped to 0..4095. sample_cur reports the noisy value.
Undefined:
- No LFSR logic; gen_sample = base exactly.

Test Plan:
- Mode 0, sample_in=0xABC, adc_clk = osc_clk/128, one conversion → adc_data bits 15..0 = 0010101011110000. An adc_com-style reader of bits 13..6 gets 0xAB. frame_done pulses once; frame_count=1.
- Mode 1, step_in=0x400, 5 frames → sample_cur sequence 0x000, 0x400, 0x800, 0xC00, 0x000 (wrap). frame_count=5.
- Mode 2, step_in=0x800, 5 frames → 0x000, 0x800, 0xFFF, 0x7FF, 0x000.
- adc_conv raised after 7 adc_clk rises → frame_abort=1 for 1 cycle; adc_data=0; frame_count unchanged. The next frame repeats the same sample_cur.
- reset driven low mid-SHIFT for 1 cycle → all outputs at reset values next cycle. A frame starts only on the next adc_conv fall.
- ADC_NOISE_EN, mode 0, sample_in=0x000 → sample_cur never below 0x000 and never above 0x003 over 64 frames. Same bench without the macro → always 0x000.
